// File: rtl/mux_sel_skid.sv
// NUM_IN:1 select mux feeding a registered two-entry skid buffer with valid/ready on both sides.
// in_ready is a function of state, flush and reset only, so no combinational path runs back from out_ready.
module mux_sel_skid #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 2,
   localparam int SEL_W = $clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    sel_err
);

   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  word, main_data, skid_data;
   logic [SEL_W-1:0]  main_sel, skid_sel;
   logic              sel_oob, acc, pop;
   logic              load_main, load_skid, shift;

   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_IN; k++)
         if (sel == SEL_W'(k)) word = in_data[k*WIDTH +: WIDTH];
   end

   // Only a non-power-of-2 channel count leaves select codes with no channel behind them.
   generate
      if ((1 << SEL_W) != NUM_IN) begin : g_oob
         assign sel_oob = (sel > SEL_W'(NUM_IN - 1));
      end else begin : g_no_oob
         assign sel_oob = 1'b0;
      end
   endgenerate

   assign in_ready  = (state != S_TWO) & ~flush & ~reset;
   assign out_valid = (state != S_EMPTY);
   assign acc       = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign out_data  = main_data;
   assign out_sel   = main_sel;

   always_ff @(posedge clk) begin
      if (reset) state <= S_EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY: if (acc) state_nxt = S_ONE;
            S_ONE: begin
               if (acc & ~pop)      state_nxt = S_TWO;
               else if (~acc & pop) state_nxt = S_EMPTY;
            end
            S_TWO:   if (pop) state_nxt = S_ONE;
            default: state_nxt = S_EMPTY;
         endcase
      end
   end

   // acc is already 0 under flush; the skid-to-main shift is gated so a flushed pop leaves data regs alone.
   always_comb begin
      load_main = 1'b0;
      load_skid = 1'b0;
      shift     = 1'b0;
      case (state)
         S_EMPTY: load_main = acc;
         S_ONE: begin
            load_main = acc & pop;
            load_skid = acc & ~pop;
         end
         S_TWO:   shift = pop & ~flush;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_data <= '0;
         main_sel  <= '0;
         skid_data <= '0;
         skid_sel  <= '0;
         sel_err   <= 1'b0;
      end else begin
         if (load_main) begin
            main_data <= word;
            main_sel  <= sel;
         end else if (shift) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
         end
         if (load_skid) begin
            skid_data <= word;
            skid_sel  <= sel;
         end
         if (acc & sel_oob) sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mux_sel_skid.sv
// Bench for mux_sel_skid: three instances (5b/2ch, 5b/3ch, 32b/4ch) driven by scenario tasks.
// Expected values come from spec constants and a queue model of a depth-2 FIFO.
module tb_mux_sel_skid;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   int nvec = 0;
   int nerr = 0;

   // instance a: WIDTH=5, NUM_IN=2
   logic        a_flush, a_sel, a_valid, a_ready, a_osel, a_ovalid, a_oready, a_err;
   logic [9:0]  a_data;
   logic [4:0]  a_odata;
   // instance b: WIDTH=5, NUM_IN=3
   logic        b_flush, b_valid, b_ready, b_ovalid, b_oready, b_err;
   logic [1:0]  b_sel, b_osel;
   logic [14:0] b_data;
   logic [4:0]  b_odata;
   // instance c: WIDTH=32, NUM_IN=4
   logic         c_flush, c_valid, c_ready, c_ovalid, c_oready, c_err;
   logic [1:0]   c_sel, c_osel;
   logic [127:0] c_data;
   logic [31:0]  c_odata;

   mux_sel_skid #(.WIDTH(5), .NUM_IN(2)) u_a (
      .clk(clk), .reset(rst), .flush(a_flush), .in_data(a_data), .sel(a_sel),
      .in_valid(a_valid), .in_ready(a_ready), .out_data(a_odata), .out_sel(a_osel),
      .out_valid(a_ovalid), .out_ready(a_oready), .sel_err(a_err));

   mux_sel_skid #(.WIDTH(5), .NUM_IN(3)) u_b (
      .clk(clk), .reset(rst), .flush(b_flush), .in_data(b_data), .sel(b_sel),
      .in_valid(b_valid), .in_ready(b_ready), .out_data(b_odata), .out_sel(b_osel),
      .out_valid(b_ovalid), .out_ready(b_oready), .sel_err(b_err));

   mux_sel_skid #(.WIDTH(32), .NUM_IN(4)) u_c (
      .clk(clk), .reset(rst), .flush(c_flush), .in_data(c_data), .sel(c_sel),
      .in_valid(c_valid), .in_ready(c_ready), .out_data(c_odata), .out_sel(c_osel),
      .out_valid(c_ovalid), .out_ready(c_oready), .sel_err(c_err));

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b0 || a_odata !== 5'h00 || a_ready !== 1'b0 || a_err !== 1'b0) begin
         nerr++;
         $display("FAIL reset_a: ovalid=%b odata=%h ready=%b err=%b, want 0 00 0 0", a_ovalid, a_odata, a_ready, a_err);
      end
      nvec++;
      if (b_ovalid !== 1'b0 || b_odata !== 5'h00 || b_ready !== 1'b0 || b_err !== 1'b0 ||
          c_ovalid !== 1'b0 || c_odata !== 32'h0 || c_ready !== 1'b0) begin
         nerr++;
         $display("FAIL reset_bc: b ovalid=%b odata=%h ready=%b err=%b c ovalid=%b odata=%h ready=%b, want all 0",
                  b_ovalid, b_odata, b_ready, b_err, c_ovalid, c_odata, c_ready);
      end
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1 || c_ready !== 1'b1 || a_ovalid !== 1'b0) begin
         nerr++;
         $display("FAIL reset_release: ready a/b/c=%b%b%b ovalid=%b, want 111 0", a_ready, b_ready, c_ready, a_ovalid);
      end
   endtask

   // Alternating/random sel with ch0=03, ch1=1F: one word per cycle, one cycle latency.
   task automatic test_stream;
      logic       prev_sel;
      logic [4:0] exp_d;
      a_data   = {5'h1F, 5'h03};
      a_oready = 1'b1;
      prev_sel = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i > 0) begin
            exp_d = prev_sel ? 5'h1F : 5'h03;
            nvec++;
            if (a_ovalid !== 1'b1 || a_odata !== exp_d || a_osel !== prev_sel || a_ready !== 1'b1) begin
               nerr++;
               $display("FAIL stream[%0d]: ovalid=%b odata=%h osel=%b ready=%b, want 1 %h %b 1",
                        i, a_ovalid, a_odata, a_osel, a_ready, exp_d, prev_sel);
            end
         end
         a_sel    = (i < 6) ? i[0] : 1'($urandom_range(0, 1));
         a_valid  = 1'b1;
         prev_sel = a_sel;
      end
      @(negedge clk);
      exp_d = prev_sel ? 5'h1F : 5'h03;
      nvec++;
      if (a_ovalid !== 1'b1 || a_odata !== exp_d) begin
         nerr++;
         $display("FAIL stream_last: ovalid=%b odata=%h, want 1 %h", a_ovalid, a_odata, exp_d);
      end
      a_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b0) begin
         nerr++;
         $display("FAIL stream_drain: ovalid=%b, want 0", a_ovalid);
      end
   endtask

   task automatic test_backpressure;
      a_oready = 1'b0;
      a_sel    = 1'b0;
      a_data   = {5'h00, 5'h0A};
      a_valid  = 1'b1;
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b1 || a_odata !== 5'h0A || a_ready !== 1'b1) begin
         nerr++;
         $display("FAIL bp_one: ovalid=%b odata=%h ready=%b, want 1 0a 1", a_ovalid, a_odata, a_ready);
      end
      a_data = {5'h00, 5'h15};
      @(negedge clk);
      a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         nvec++;
         if (a_ovalid !== 1'b1 || a_odata !== 5'h0A || a_ready !== 1'b0) begin
            nerr++;
            $display("FAIL bp_hold[%0d]: ovalid=%b odata=%h ready=%b, want 1 0a 0", i, a_ovalid, a_odata, a_ready);
         end
         @(negedge clk);
      end
      a_oready = 1'b1;
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b1 || a_odata !== 5'h15 || a_ready !== 1'b1) begin
         nerr++;
         $display("FAIL bp_second: ovalid=%b odata=%h ready=%b, want 1 15 1", a_ovalid, a_odata, a_ready);
      end
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b0 || a_ready !== 1'b1) begin
         nerr++;
         $display("FAIL bp_empty: ovalid=%b ready=%b, want 0 1", a_ovalid, a_ready);
      end
   endtask

   task automatic test_flush_two;
      a_oready = 1'b0;
      a_sel    = 1'b1;
      a_valid  = 1'b1;
      a_data   = {5'h07, 5'h00};
      @(negedge clk);
      a_data = {5'h19, 5'h00};
      @(negedge clk);
      // buffer is TWO: flush with pop and offer in the same cycle
      a_data   = {5'h0C, 5'h00};
      a_flush  = 1'b1;
      a_oready = 1'b1;
      #1;
      nvec++;
      if (a_ready !== 1'b0 || a_ovalid !== 1'b1 || a_odata !== 5'h07) begin
         nerr++;
         $display("FAIL flush_cycle: ready=%b ovalid=%b odata=%h, want 0 1 07", a_ready, a_ovalid, a_odata);
      end
      @(negedge clk);
      a_flush = 1'b0;
      a_valid = 1'b0;
      #1;
      nvec++;
      if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_odata !== 5'h07) begin
         nerr++;
         $display("FAIL flush_after: ovalid=%b ready=%b odata=%h, want 0 1 07", a_ovalid, a_ready, a_odata);
      end
      @(negedge clk);
      nvec++;
      if (a_ovalid !== 1'b0) begin
         nerr++;
         $display("FAIL flush_noaccept: ovalid=%b, want 0", a_ovalid);
      end
   endtask

   task automatic test_out_of_range;
      logic [1:0] prev_sel;
      b_data   = {5'h11, 5'h11, 5'h11};
      b_oready = 1'b1;
      b_valid  = 1'b1;
      b_sel    = 2'($urandom_range(0, 2));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nvec++;
         if (b_ovalid !== 1'b1 || b_odata !== 5'h11 || b_osel !== b_sel || b_err !== 1'b0) begin
            nerr++;
            $display("FAIL oor_pre[%0d]: ovalid=%b odata=%h osel=%0d err=%b, want 1 11 %0d 0",
                     i, b_ovalid, b_odata, b_osel, b_err, b_sel);
         end
         b_sel = (i == 3) ? 2'd3 : 2'($urandom_range(0, 2));
      end
      prev_sel = b_sel;
      @(negedge clk);
      nvec++;
      if (b_ovalid !== 1'b1 || b_odata !== 5'h00 || b_osel !== prev_sel || b_err !== 1'b1) begin
         nerr++;
         $display("FAIL oor_hit: ovalid=%b odata=%h osel=%0d err=%b, want 1 00 3 1", b_ovalid, b_odata, b_osel, b_err);
      end
      for (int i = 0; i < 6; i++) begin
         b_sel = 2'($urandom_range(0, 2));
         prev_sel = b_sel;
         @(negedge clk);
         nvec++;
         if (b_odata !== 5'h11 || b_osel !== prev_sel || b_err !== 1'b1) begin
            nerr++;
            $display("FAIL oor_sticky[%0d]: odata=%h osel=%0d err=%b, want 11 %0d 1", i, b_odata, b_osel, b_err, prev_sel);
         end
      end
      b_flush = 1'b1;
      @(negedge clk);
      b_flush = 1'b0;
      b_valid = 1'b0;
      nvec++;
      if (b_err !== 1'b1 || b_ovalid !== 1'b0) begin
         nerr++;
         $display("FAIL oor_flush: err=%b ovalid=%b, want 1 0", b_err, b_ovalid);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      nvec++;
      if (b_err !== 1'b0) begin
         nerr++;
         $display("FAIL oor_reset: err=%b, want 0", b_err);
      end
   endtask

   // Random valid/ready/flush on the 32b x 4 instance against a depth-2 FIFO queue model.
   task automatic test_random_sweep;
      logic [31:0] qd[$];
      logic [1:0]  qs[$];
      logic        exp_rdy, exp_v, acc, pop;
      logic [31:0] exp_d;
      logic [1:0]  exp_s;
      int          bad = 0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         c_valid  = ($urandom_range(0, 3) != 0);
         c_oready = ($urandom_range(0, 2) != 0);
         c_flush  = ($urandom_range(0, 63) == 0);
         c_data   = {$urandom, $urandom, $urandom, $urandom};
         c_sel    = 2'($urandom_range(0, 3));
         #1;
         exp_rdy = (qd.size() < 2) && !c_flush;
         exp_v   = (qd.size() != 0);
         exp_d   = '0;
         exp_s   = '0;
         if (exp_v) begin
            exp_d = qd[0];
            exp_s = qs[0];
         end
         nvec++;
         if (c_ready !== exp_rdy || c_ovalid !== exp_v || c_err !== 1'b0 ||
             (exp_v && (c_odata !== exp_d || c_osel !== exp_s))) begin
            nerr++;
            if (bad < 10)
               $display("FAIL sweep[%0d]: ready=%b ovalid=%b odata=%h osel=%0d err=%b, want %b %b %h %0d 0",
                        cyc, c_ready, c_ovalid, c_odata, c_osel, c_err, exp_rdy, exp_v, exp_d, exp_s);
            bad++;
         end
         acc = c_valid && exp_rdy;
         pop = exp_v && c_oready;
         if (pop) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
         end
         if (c_flush) begin
            qd.delete();
            qs.delete();
         end
         if (acc) begin
            qd.push_back(c_data[c_sel*32 +: 32]);
            qs.push_back(c_sel);
         end
      end
      @(negedge clk);
      c_valid = 1'b0;
      c_flush = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_flush = 1'b0; a_data = '0; a_sel = '0; a_valid = 1'b0; a_oready = 1'b0;
      b_flush = 1'b0; b_data = '0; b_sel = '0; b_valid = 1'b0; b_oready = 1'b0;
      c_flush = 1'b0; c_data = '0; c_sel = '0; c_valid = 1'b0; c_oready = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush_two();
      test_out_of_range();
      test_random_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
